// File: rtl/irq_entry_ctrl.sv
// Interrupt entry/return sequencer between intc and the MIPS fetch stage.
// Waits for an instruction boundary, saves the return PC, redirects fetch and handles eret.
module irq_entry_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int IACK_CYCLES = 1,
    parameter bit IE_RESET    = 1'b1,
    parameter int SPUR_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              irq,
    input  logic [ADDR_W-1:0] isr_addr,
    input  logic [ADDR_W-1:0] pc_next,
    input  logic              instr_boundary,
    input  logic              eret,
    input  logic              ie_set,
    input  logic              ie_clr,
    output logic              iack,
    output logic              pc_redirect,
    output logic [ADDR_W-1:0] pc_target,
    output logic [ADDR_W-1:0] epc,
    output logic              in_isr,
    output logic              ie,
    output logic [SPUR_W-1:0] spur_cnt
);

    typedef enum logic [1:0] {IDLE, ARMED, ACK, IN_ISR} state_t;

    localparam int CNT_W = (IACK_CYCLES > 1) ? $clog2(IACK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] ACK_LOAD = CNT_W'(IACK_CYCLES - 1);

    state_t            state, state_d;
    logic [CNT_W-1:0]  ack_cnt, ack_cnt_d;
    logic              iack_d, pc_redirect_d, in_isr_d, ie_d;
    logic [ADDR_W-1:0] pc_target_d, epc_d;
    logic [SPUR_W-1:0] spur_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ack_cnt     <= '0;
            iack        <= 1'b0;
            pc_redirect <= 1'b0;
            pc_target   <= '0;
            epc         <= '0;
            in_isr      <= 1'b0;
            ie          <= IE_RESET;
            spur_cnt    <= '0;
        end else begin
            state       <= state_d;
            ack_cnt     <= ack_cnt_d;
            iack        <= iack_d;
            pc_redirect <= pc_redirect_d;
            pc_target   <= pc_target_d;
            epc         <= epc_d;
            in_isr      <= in_isr_d;
            ie          <= ie_d;
            spur_cnt    <= spur_cnt_d;
        end
    end

    // Every output is the registered copy of its _d value; pc_redirect is the only one that self-clears.
    always_comb begin
        state_d       = state;
        ack_cnt_d     = ack_cnt;
        iack_d        = iack;
        pc_redirect_d = 1'b0;
        pc_target_d   = pc_target;
        epc_d         = epc;
        in_isr_d      = in_isr;
        ie_d          = ie;
        spur_cnt_d    = spur_cnt;

        if (state == IDLE || state == ARMED) begin
            if (ie_clr)
                ie_d = 1'b0;
            else if (ie_set)
                ie_d = 1'b1;
        end

        case (state)
            IDLE: begin
                if (irq && ie && !ie_clr)
                    state_d = ARMED;
            end
            ARMED: begin
                if (!irq) begin
                    state_d = IDLE;
                    if (spur_cnt != '1)
                        spur_cnt_d = spur_cnt + SPUR_W'(1);
                end else if (ie_clr) begin
                    state_d = IDLE;
                end else if (instr_boundary) begin
                    state_d       = ACK;
                    epc_d         = pc_next;
                    pc_target_d   = isr_addr;
                    ie_d          = 1'b0;
                    pc_redirect_d = 1'b1;
                    iack_d        = 1'b1;
                    in_isr_d      = 1'b1;
                    ack_cnt_d     = ACK_LOAD;
                end
            end
            ACK: begin
                if (ack_cnt == '0) begin
                    state_d = IN_ISR;
                    iack_d  = 1'b0;
                end else begin
                    ack_cnt_d = ack_cnt - CNT_W'(1);
                end
            end
            IN_ISR: begin
                // Nested irq is deliberately not looked at; IDLE picks it up after the return.
                if (eret) begin
                    state_d       = IDLE;
                    pc_target_d   = epc;
                    ie_d          = 1'b1;
                    pc_redirect_d = 1'b1;
                    in_isr_d      = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_irq_entry_ctrl.sv
// Scoreboard bench for irq_entry_ctrl: expected redirects are queued by the stimulus
// and popped by a monitor whenever pc_redirect is seen; steady-state outputs are checked directly.
module tb_irq_entry_ctrl;

    localparam int ADDR_W = 32;
    localparam int IACK_N = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              irq, instr_boundary, eret, ie_set, ie_clr;
    logic [ADDR_W-1:0] isr_addr, pc_next;
    logic              iack, pc_redirect, in_isr, ie;
    logic [ADDR_W-1:0] pc_target, epc;
    logic [7:0]        spur_cnt;

    typedef struct {
        logic [ADDR_W-1:0] target;
        logic [ADDR_W-1:0] epc;
        logic              ie;
        logic              in_isr;
        logic              iack;
    } redirect_t;

    redirect_t exp_q[$];
    int errors = 0;
    int checks = 0;

    irq_entry_ctrl #(
        .ADDR_W(ADDR_W), .IACK_CYCLES(IACK_N), .IE_RESET(1'b1), .SPUR_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .irq(irq), .isr_addr(isr_addr), .pc_next(pc_next),
        .instr_boundary(instr_boundary), .eret(eret), .ie_set(ie_set), .ie_clr(ie_clr),
        .iack(iack), .pc_redirect(pc_redirect), .pc_target(pc_target), .epc(epc),
        .in_isr(in_isr), .ie(ie), .spur_cnt(spur_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [ADDR_W-1:0] actual,
                               input logic [ADDR_W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pushRedirect(input logic [ADDR_W-1:0] target, input logic [ADDR_W-1:0] e,
                                input logic ie_v, input logic isr_v, input logic iack_v);
        redirect_t r;
        r.target = target;
        r.epc    = e;
        r.ie     = ie_v;
        r.in_isr = isr_v;
        r.iack   = iack_v;
        exp_q.push_back(r);
    endtask

    // Monitor: every redirect pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && pc_redirect) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_redirect", pc_target, '1);
            end else begin
                redirect_t r;
                r = exp_q.pop_front();
                checkOutput("redir_target", pc_target, r.target);
                checkOutput("redir_epc", epc, r.epc);
                checkOutput("redir_ie", 32'(ie), 32'(r.ie));
                checkOutput("redir_in_isr", 32'(in_isr), 32'(r.in_isr));
                checkOutput("redir_iack", 32'(iack), 32'(r.iack));
            end
        end
    end

    initial begin
        rst_n = 1'b0; irq = 0; instr_boundary = 0; eret = 0; ie_set = 0; ie_clr = 0;
        isr_addr = '0; pc_next = '0;
        #12;
        checkOutput("rst_iack", 32'(iack), 0);
        checkOutput("rst_redirect", 32'(pc_redirect), 0);
        checkOutput("rst_target", pc_target, 0);
        checkOutput("rst_epc", epc, 0);
        checkOutput("rst_ie", 32'(ie), 1);
        checkOutput("rst_spur", 32'(spur_cnt), 0);
        rst_n = 1'b1;
        applyStimulus(1);

        // Entry
        irq = 1; isr_addr = 32'h00060000; pc_next = 32'h00400024;
        applyStimulus(2);
        checkOutput("armed_no_iack", 32'(iack), 0);
        instr_boundary = 1;
        pushRedirect(32'h00060000, 32'h00400024, 1'b0, 1'b1, 1'b1);
        applyStimulus(1);
        instr_boundary = 0; irq = 0; ie_set = 1;
        checkOutput("entry_iack", 32'(iack), 1);
        checkOutput("entry_ie", 32'(ie), 0);
        applyStimulus(1);
        ie_set = 0;
        checkOutput("ack_iack_hold", 32'(iack), 1);
        checkOutput("ack_redirect_once", 32'(pc_redirect), 0);
        checkOutput("ack_ie_set_ignored", 32'(ie), 0);
        applyStimulus(1);
        checkOutput("isr_iack_low", 32'(iack), 0);
        checkOutput("isr_in_isr", 32'(in_isr), 1);

        // Return
        eret = 1;
        pushRedirect(32'h00400024, 32'h00400024, 1'b1, 1'b0, 1'b0);
        applyStimulus(1);
        eret = 0;
        applyStimulus(1);
        checkOutput("ret_redirect_once", 32'(pc_redirect), 0);
        checkOutput("ret_target_hold", pc_target, 32'h00400024);

        // eret outside an ISR, then spurious requests
        eret = 1;
        applyStimulus(1);
        eret = 0;
        checkOutput("eret_idle_ie", 32'(ie), 1);
        irq = 1;
        applyStimulus(2);
        irq = 0;
        applyStimulus(1);
        checkOutput("spur_one", 32'(spur_cnt), 1);
        checkOutput("spur_no_iack", 32'(iack), 0);
        for (int i = 0; i < 259; i++) begin
            irq = 1;
            applyStimulus(1);
            irq = 0;
            applyStimulus(1);
        end
        checkOutput("spur_saturated", 32'(spur_cnt), 32'hFF);

        // No nesting, then back-to-back entry after eret
        irq = 1; isr_addr = 32'h00060000; pc_next = 32'h00400100;
        applyStimulus(1);
        instr_boundary = 1;
        pushRedirect(32'h00060000, 32'h00400100, 1'b0, 1'b1, 1'b1);
        applyStimulus(1);
        instr_boundary = 0;
        applyStimulus(IACK_N);
        isr_addr = 32'h00040000;
        applyStimulus(3);
        checkOutput("nest_no_iack", 32'(iack), 0);
        checkOutput("nest_in_isr", 32'(in_isr), 1);
        eret = 1;
        pushRedirect(32'h00400100, 32'h00400100, 1'b1, 1'b0, 1'b0);
        applyStimulus(1);
        eret = 0;
        applyStimulus(1);
        checkOutput("reentry_armed_no_iack", 32'(iack), 0);
        instr_boundary = 1;
        pushRedirect(32'h00040000, 32'h00400100, 1'b0, 1'b1, 1'b1);
        applyStimulus(1);
        instr_boundary = 0; irq = 0;
        applyStimulus(IACK_N);
        eret = 1;
        pushRedirect(32'h00400100, 32'h00400100, 1'b1, 1'b0, 1'b0);
        applyStimulus(1);
        eret = 0;
        applyStimulus(1);

        // ie_clr beats boundary in ARMED; ie_clr beats ie_set
        irq = 1;
        applyStimulus(1);
        ie_clr = 1; instr_boundary = 1;
        applyStimulus(1);
        ie_clr = 0; instr_boundary = 0;
        checkOutput("prio_ie", 32'(ie), 0);
        checkOutput("prio_no_entry", 32'(in_isr), 0);
        applyStimulus(2);
        checkOutput("prio_idle_no_iack", 32'(iack), 0);
        ie_set = 1;
        applyStimulus(1);
        checkOutput("ie_set", 32'(ie), 1);
        ie_clr = 1;
        applyStimulus(1);
        ie_set = 0; ie_clr = 0; irq = 0;
        checkOutput("ie_set_clr", 32'(ie), 0);
        ie_set = 1;
        applyStimulus(1);
        ie_set = 0;

        // Asynchronous reset in the middle of ACK
        irq = 1; isr_addr = 32'h00070000; pc_next = 32'h00400200;
        applyStimulus(1);
        instr_boundary = 1;
        pushRedirect(32'h00070000, 32'h00400200, 1'b0, 1'b1, 1'b1);
        applyStimulus(1);
        instr_boundary = 0; irq = 0;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_iack", 32'(iack), 0);
        checkOutput("async_redirect", 32'(pc_redirect), 0);
        checkOutput("async_in_isr", 32'(in_isr), 0);
        checkOutput("async_ie", 32'(ie), 1);
        checkOutput("async_spur", 32'(spur_cnt), 0);
        checkOutput("async_epc", epc, 0);
        checkOutput("queue_drained", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
